// File: rtl/mem_byte_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_byte_seq_pkg
//   Shared definitions for the MEM-stage byte sequencer.
//   - size codes for the request size field
//   - read/write codes driven on the controller's mc_rw port
//   - FSM state encoding
//   - helper that maps a size code to the index of its last byte
// ---------------------------------------------------------------------------
package mem_byte_seq_pkg;

    // Request size codes; the unused code 2'b11 is handled as a word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Transfer direction codes presented to the memory controller.
    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_LOAD  = 2'b01;
    localparam logic [1:0] RW_STORE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } seq_state_t;

    // Index of the final byte of a request (N-1). Anything that is not a
    // byte or half falls through to the word case, which is how size 11
    // ends up behaving exactly like a word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// ---------------------------------------------------------------------------
// mem_load_ext
//   Purely combinational load-result extender. Takes the little-endian
//   assembled load bytes and widens them to 32 bits according to the size
//   of the access, either sign- or zero-extending.
//
//   Ports
//     assembly   in  32  assembled bytes, byte 0 in [7:0]
//     size       in   2  SZ_B / SZ_H / SZ_W (11 treated as word)
//     is_signed  in   1  1 = sign-extend, 0 = zero-extend
//     rdata      out 32  extended result
// ---------------------------------------------------------------------------
module mem_load_ext
    import mem_byte_seq_pkg::*;
(
    input  logic [31:0] assembly,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] rdata
);

    // Bytes above the access size are ignored; the fill bit is the top bit
    // of the accessed data when signed, otherwise zero. Words pass through.
    always_comb begin
        rdata = assembly;
        case (size)
            SZ_B:    rdata = {{24{is_signed & assembly[7]}},  assembly[7:0]};
            SZ_H:    rdata = {{16{is_signed & assembly[15]}}, assembly[15:0]};
            default: rdata = assembly;
        endcase
    end

endmodule

// File: rtl/mem_byte_seq.sv
// ---------------------------------------------------------------------------
// mem_byte_seq
//   MEM-stage initiator for the byte-wide memory controller. One 32-bit
//   load/store request is broken into 1, 2 or 4 single-byte transfers on the
//   controller port. Load bytes are assembled little-endian and then sign- or
//   zero-extended; done pulses exactly once per request.
//
//   Parameters
//     ADDR_W      address width; byte addresses wrap modulo 2^ADDR_W
//
//   Ports
//     clk         in   1       rising-edge clock
//     rst         in   1       synchronous active-high reset
//     req_valid   in   1       request present (only looked at in IDLE)
//     req_we      in   1       1 = store, 0 = load
//     req_size    in   2       00 byte, 01 half, 10/11 word
//     req_signed  in   1       load extension mode
//     req_addr    in   ADDR_W  base byte address, any alignment
//     req_wdata   in   32      store data, byte i in [8i+7:8i]
//     busy        out  1       sequencer not in IDLE
//     done        out  1       one-cycle completion pulse
//     rdata       out  32      extended load result, held until next load
//     mc_flag     out  1       byte transfer requested this cycle
//     mc_rw       out  2       RW_IDLE / RW_LOAD / RW_STORE
//     mc_addr     out  ADDR_W  byte address of the current transfer
//     mc_wdata    out  8       store byte of the current transfer
//     mc_grant    in   1       controller accepts the transfer this cycle
//     mc_rdata    in   8       load byte, valid the cycle after a load grant
// ---------------------------------------------------------------------------
module mem_byte_seq
    import mem_byte_seq_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              mc_flag,
    output logic [1:0]        mc_rw,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_wdata,
    input  logic              mc_grant,
    input  logic [7:0]        mc_rdata
);

    seq_state_t        state;
    seq_state_t        next_state;

    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;

    logic [1:0]        issue_idx;
    logic [1:0]        cap_idx;
    logic              pending;
    logic [31:0]       assembly;
    logic [31:0]       asm_next;
    logic [31:0]       ext_data;
    logic [31:0]       rdata_q;
    logic [7:0]        issue_byte;
    logic              last_beat;

    assign last_beat = (issue_idx == last_index(size_q));
    assign rdata     = rdata_q;

    // Store byte for the current issue index.
    always_comb begin
        issue_byte = wdata_q[7:0];
        case (issue_idx)
            2'd0: issue_byte = wdata_q[7:0];
            2'd1: issue_byte = wdata_q[15:8];
            2'd2: issue_byte = wdata_q[23:16];
            2'd3: issue_byte = wdata_q[31:24];
            default: issue_byte = wdata_q[7:0];
        endcase
    end

    // State register. Reset drops straight back to IDLE from anywhere, which
    // aborts an in-flight request without ever raising done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and controller-port outputs. The port is only driven in
    // XFER; everywhere else it is forced to all zeros. A stalled transfer
    // (grant low) simply keeps the same state and index, so every output
    // holds. Stores finish right after the last grant; loads spend one WAIT
    // cycle collecting the final returned byte.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        mc_flag    = 1'b0;
        mc_rw      = RW_IDLE;
        mc_addr    = '0;
        mc_wdata   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_valid) begin
                    next_state = XFER;
                end
            end
            XFER: begin
                mc_flag  = 1'b1;
                mc_rw    = we_q ? RW_STORE : RW_LOAD;
                mc_addr  = base_addr + ADDR_W'(issue_idx);
                mc_wdata = issue_byte;
                if (mc_grant && last_beat) begin
                    next_state = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Assembly value including the byte arriving this cycle. It is computed
    // ahead of the register so the WAIT->DONE edge can extend the complete
    // word and rdata is already valid while done is high.
    always_comb begin
        asm_next = assembly;
        if (pending) begin
            case (cap_idx)
                2'd0: asm_next[7:0]   = mc_rdata;
                2'd1: asm_next[15:8]  = mc_rdata;
                2'd2: asm_next[23:16] = mc_rdata;
                2'd3: asm_next[31:24] = mc_rdata;
                default: asm_next = assembly;
            endcase
        end
    end

    mem_load_ext u_ext (
        .assembly  (asm_next),
        .size      (size_q),
        .is_signed (signed_q),
        .rdata     (ext_data)
    );

    // Request capture, issue/capture counters and load assembly.
    // pending marks that the previous cycle carried a granted load, so the
    // controller's read byte is on mc_rdata now; captures therefore trail
    // issues by one cycle and may overlap with later issues. rdata is only
    // written on the way into DONE for loads, so stores and aborted loads
    // never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            signed_q  <= 1'b0;
            issue_idx <= '0;
            cap_idx   <= '0;
            pending   <= 1'b0;
            assembly  <= '0;
            rdata_q   <= '0;
        end else begin
            pending <= (state == XFER) && mc_grant && !we_q;

            if (pending) begin
                assembly <= asm_next;
                cap_idx  <= cap_idx + 2'd1;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_addr <= req_addr;
                        wdata_q   <= req_wdata;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        issue_idx <= '0;
                        cap_idx   <= '0;
                        assembly  <= '0;
                    end
                end
                XFER: begin
                    if (mc_grant) begin
                        issue_idx <= issue_idx + 2'd1;
                    end
                end
                WAIT: begin
                    rdata_q <= ext_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_byte_seq
//   Self-checking bench for mem_byte_seq. A byte-addressed memory model
//   answers load transfers one cycle after the grant and absorbs stores.
//   Directed vectors come from a table, a few multi-cycle cases are written
//   out by hand, and random requests are checked against a reference that
//   works directly from byte addresses and integer arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_byte_seq;

    typedef struct {
        int          rel;
        logic        grant;
        logic [31:0] addr;
        logic [1:0]  rw;
        logic [7:0]  wdata;
    } xfer_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] preload;
        logic [31:0] exp_rdata;
        int          exp_done;
        bit          pulse;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        mc_flag;
    logic [1:0]  mc_rw;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic        mc_grant = 1'b1;
    logic [7:0]  mc_rdata = '0;

    int          cyc = 0;
    int          start_cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          done_cnt = 0;
    int          done_rel = -1;
    int          idle_bad = 0;
    logic [31:0] done_rdata = '0;
    bit          rd_pend = 0;
    logic [31:0] rd_addr = '0;
    int          grant_mode = 0;
    int          stall_lo = 0;
    int          stall_hi = 0;
    logic [31:0] exp_held = '0;

    logic [7:0]  mem [logic [31:0]];
    xfer_t       trace_q [$];
    xfer_t       grant_q [$];
    vec_t        vecs [$];

    mem_byte_seq #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .mc_flag    (mc_flag),
        .mc_rw      (mc_rw),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata),
        .mc_grant   (mc_grant),
        .mc_rdata   (mc_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory content: explicit writes win, otherwise a fixed address hash.
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Reference load result straight from memory bytes and integer ranges.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        int     n;
        longint v;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        v = 0;
        for (int k = 0; k < n; k++) begin
            v += longint'(mem_rd(addr + 32'(k))) << (8 * k);
        end
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) begin
            v -= longint'(1) << (8 * n);
        end
        return 32'(v);
    endfunction

    // Controller side, just after each rising edge: return the byte of a
    // load granted in the previous cycle (garbage otherwise) and set grant.
    always @(posedge clk) begin
        int rel;
        #1;
        if (rd_pend) begin
            mc_rdata = mem_rd(rd_addr);
            rd_pend  = 0;
        end else begin
            mc_rdata = 8'($urandom);
        end
        rel = cyc - start_cyc;
        case (grant_mode)
            0:       mc_grant = 1'b1;
            1:       mc_grant = ($urandom_range(0, 3) != 0);
            default: mc_grant = !(rel >= stall_lo && rel <= stall_hi);
        endcase
    end

    // Mid-cycle monitor: logs transfers, performs granted stores into the
    // memory model, watches idle port values and done pulses.
    always @(negedge clk) begin
        xfer_t t;
        int    rel;
        rel = cyc - start_cyc;
        if (mc_flag) begin
            t.rel   = rel;
            t.grant = mc_grant;
            t.addr  = mc_addr;
            t.rw    = mc_rw;
            t.wdata = mc_wdata;
            trace_q.push_back(t);
            if (mc_grant) begin
                grant_q.push_back(t);
                if (mc_rw == 2'b10) begin
                    mem[mc_addr] = mc_wdata;
                end else if (mc_rw == 2'b01) begin
                    rd_pend = 1;
                    rd_addr = mc_addr;
                end
            end
        end else if (mc_rw != 2'b00 || mc_addr != 32'h0 || mc_wdata != 8'h0) begin
            idle_bad++;
        end
        if (done) begin
            done_cnt++;
            done_rel   = rel;
            done_rdata = rdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request for cycle 0, then drop req_valid and scramble the
    // request fields so the design must rely on what it latched.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #2;
        start_cyc  = cyc;
        trace_q.delete();
        grant_q.delete();
        done_cnt   = 0;
        done_rel   = -1;
        idle_bad   = 0;
        done_rdata = 32'hBAD0_BAD0;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #2;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        checkOutput({name, "_done_count"}, done_cnt, 1);
    endtask

    // Expected byte transfers: N bytes at base+k (wrapping), in order, with
    // the right direction and, for stores, byte k of the data. With grant
    // held high, byte k must be issued in cycle k+1.
    task automatic check_xfers(input string name, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          bad;
        logic [31:0] a;
        logic [31:0] sh;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        bad = 0;
        if (grant_q.size() != n) begin
            bad++;
        end else begin
            for (int k = 0; k < n; k++) begin
                a  = addr + 32'(k);
                sh = wdata >> (8 * k);
                if (grant_q[k].addr !== a) bad++;
                if (grant_q[k].rw !== (we ? 2'b10 : 2'b01)) bad++;
                if (we && grant_q[k].wdata !== sh[7:0]) bad++;
                if (grant_mode == 0 && grant_q[k].rel != k + 1) bad++;
            end
        end
        checkOutput({name, "_xfers"}, bad, 0);
    endtask

    task automatic run_request(input string name, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input int exp_done, input bit pulse);
        applyStimulus(we, size, sgn, addr, wdata);
        if (pulse) begin
            @(posedge clk);
            #2;
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h0000_0700;
            @(posedge clk);
            #2;
            req_valid = 1'b0;
        end
        wait_done(name, 200);
        check_xfers(name, we, size, addr, wdata);
        checkOutput({name, "_rdata"}, done_rdata, exp_rdata);
        if (exp_done >= 0) begin
            checkOutput({name, "_latency"}, done_rel, exp_done);
        end
        checkOutput({name, "_idle_port"}, idle_bad, 0);
    endtask

    function automatic logic [31:0] addr_at(input int rel);
        foreach (trace_q[k]) begin
            if (trace_q[k].rel == rel) return trace_q[k].addr;
        end
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",     busy,     0);
        checkOutput("rst_done",     done,     0);
        checkOutput("rst_mc_flag",  mc_flag,  0);
        checkOutput("rst_mc_rw",    mc_rw,    0);
        checkOutput("rst_mc_addr",  mc_addr,  0);
        checkOutput("rst_mc_wdata", mc_wdata, 0);
        checkOutput("rst_rdata",    rdata,    0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic [31:0] stored;

        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 32'h1234_5678, 6, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0040, 32'h0, 32'h0000_0080, 32'hFFFF_FF80, 3, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0080, 32'h0000_0080, 3, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0050, 32'h0, 32'h0000_8534, 32'hFFFF_8534, 4, 1'b0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h0000_BEEF, 32'h0, 32'hFFFF_8534, 3, 1'b0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 6, 1'b1});
        vecs.push_back('{1'b0, 2'b11, 1'b1, 32'h0000_0010, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF, 6, 1'b0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0060, 32'h0, 32'h1111_FFFF, 32'h0000_FFFF, 4, 1'b0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0070, 32'h0, 32'h0000_007F, 32'h0000_007F, 3, 1'b0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0090, 32'h0000_00A5, 32'h0, 32'h0000_007F, 2, 1'b0});

        do_reset();

        grant_mode = 0;
        foreach (vecs[i]) begin
            if (!vecs[i].we) begin
                for (int k = 0; k < 4; k++) begin
                    addr = vecs[i].addr + 32'(k);
                    stored = vecs[i].preload >> (8 * k);
                    mem[addr] = stored[7:0];
                end
            end
            run_request($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
                        vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_done, vecs[i].pulse);
        end
        exp_held = 32'h0000_007F;
        stored = {mem_rd(32'h202), mem_rd(32'h201)};
        checkOutput("sh_mem_bytes", stored, 32'h0000_BEEF);

        // Store with the controller stalling in cycles 2 and 3.
        grant_mode = 2;
        stall_lo   = 2;
        stall_hi   = 3;
        run_request("sw_stall", 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, exp_held, 7, 1'b0);
        checkOutput("sw_stall_addr_c2", addr_at(2), 32'h0000_0301);
        checkOutput("sw_stall_addr_c3", addr_at(3), 32'h0000_0301);
        checkOutput("sw_stall_addr_c4", addr_at(4), 32'h0000_0301);
        checkOutput("sw_stall_grants", grant_q.size(), 4);
        stored = {mem_rd(32'h303), mem_rd(32'h302), mem_rd(32'h301), mem_rd(32'h300)};
        checkOutput("sw_stall_mem", stored, 32'hDEAD_BEEF);

        // Reset in the middle of a word load: abort, no done, rdata untouched.
        grant_mode = 0;
        do_reset();
        run_request("pre_abort_sb", 1'b1, 2'b00, 1'b0, 32'h0000_0480, 32'h0000_0033, 32'h0, 2, 1'b0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy",    busy,    0);
        checkOutput("abort_mc_flag", mc_flag, 0);
        checkOutput("abort_done",    done,    0);
        repeat (8) @(negedge clk);
        #1;
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_rdata",   rdata,    0);
        exp_held = 32'h0;

        // Randomized requests with a randomly stalling controller.
        grant_mode = 1;
        for (int r = 0; r < 40; r++) begin
            we    = 1'($urandom);
            size  = 2'($urandom);
            sgn   = 1'($urandom);
            addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            wdata = $urandom;
            exp   = we ? exp_held : ref_load(addr, size, sgn);
            run_request($sformatf("rand%0d", r), we, size, sgn, addr, wdata, exp, -1, 1'b0);
            exp_held = exp;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
